// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: turns a single-port RAM with a combinational read into a FIFO.
// It adds a one-word output holding register and valid/ready handshakes on
// both sides. A read of the next word (refill) takes priority over a write,
// because the RAM port cannot read and write in the same cycle.
module ram_fifo_ctrl #(
  parameter int AddressSize = 4,
  parameter int WordSize    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WordSize-1:0]    in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WordSize-1:0]    out_data,
  output logic [AddressSize:0]   level,
  output logic [AddressSize-1:0] ram_address,
  output logic [WordSize-1:0]    ram_data_in,
  output logic                   ram_we,
  output logic                   ram_oe,
  input  logic [WordSize-1:0]    ram_data_out
);

  localparam logic [AddressSize:0]   COUNT_ZERO  = {(AddressSize+1){1'b0}};
  localparam logic [AddressSize:0]   COUNT_ONE   = (AddressSize+1)'(1'b1);
  localparam logic [AddressSize:0]   COUNT_FULL  = {1'b1, {AddressSize{1'b0}}};
  localparam logic [AddressSize-1:0] PTR_ZERO    = {AddressSize{1'b0}};
  localparam logic [AddressSize-1:0] PTR_ONE     = AddressSize'(1'b1);
  localparam logic [WordSize-1:0]    WORD_ZERO   = {WordSize{1'b0}};

  logic [AddressSize-1:0] wr_ptr;
  logic [AddressSize-1:0] rd_ptr;
  logic [AddressSize:0]   ram_count;
  logic                   refill;
  logic                   push;

  // Handshake and RAM pin control; a refill read blocks any push that cycle.
  always_comb begin
    refill      = (ram_count != COUNT_ZERO) && (!out_valid || out_ready);
    in_ready    = rst_n && !refill && (ram_count != COUNT_FULL);
    push        = in_valid && in_ready;
    ram_we      = push;
    ram_oe      = refill;
    ram_data_in = in_data;
    if (refill) begin
      ram_address = rd_ptr;
    end else begin
      ram_address = wr_ptr;
    end
    level = ram_count + {{AddressSize{1'b0}}, out_valid};
  end

  // Holding register: load on refill (even while being popped), empty on a bare pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= WORD_ZERO;
    end else if (refill) begin
      out_valid <= 1'b1;
      out_data  <= ram_data_out;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

  // RAM pointers and occupancy; refill and push never coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= PTR_ZERO;
      rd_ptr    <= PTR_ZERO;
      ram_count <= COUNT_ZERO;
    end else begin
      case ({refill, push})
        2'b10: begin
          rd_ptr    <= rd_ptr + PTR_ONE;
          ram_count <= ram_count - COUNT_ONE;
        end
        2'b01: begin
          wr_ptr    <= wr_ptr + PTR_ONE;
          ram_count <= ram_count + COUNT_ONE;
        end
        default: begin
          ram_count <= ram_count;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed testbench for ram_fifo_ctrl with a behavioural single-port RAM.
module tb_ram_fifo_ctrl;

  localparam int AW = 2;
  localparam int DW = 8;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [AW:0]   level;
  logic [AW-1:0] ram_address;
  logic [DW-1:0] ram_data_in;
  logic          ram_we;
  logic          ram_oe;
  logic [DW-1:0] ram_data_out;

  logic [DW-1:0] mem [4];

  int checks = 0;
  int errors = 0;

  ram_fifo_ctrl #(.AddressSize(AW), .WordSize(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level),
    .ram_address(ram_address), .ram_data_in(ram_data_in),
    .ram_we(ram_we), .ram_oe(ram_oe), .ram_data_out(ram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM: write on edge, combinational read, 0 while writing.
  always @(posedge clk) begin
    if (ram_we) mem[ram_address] <= ram_data_in;
  end
  assign ram_data_out = (ram_oe && !ram_we) ? mem[ram_address] : 8'h00;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_push(input logic [DW-1:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    while (in_ready !== 1'b1 && n < 20) begin
      tick();
      #1;
      n++;
    end
    chk("push_accept", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_pop(input logic [DW-1:0] exp);
    int n;
    n = 0;
    out_ready = 1'b1;
    #1;
    while (out_valid !== 1'b1 && n < 20) begin
      tick();
      #1;
      n++;
    end
    chk("pop_valid", 32'(out_valid), 32'd1);
    chk("pop_data", 32'(out_data), 32'(exp));
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with a push request pending.
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h33; out_ready = 1'b0;
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    tick();
    chk("rst_edge_ram_we", 32'(ram_we), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Single word 0x11.
    in_valid = 1'b1; in_data = 8'h11;
    #1;
    chk("sw_c0_we", 32'(ram_we), 32'd1);
    chk("sw_c0_addr", 32'(ram_address), 32'd0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("sw_c1_oe", 32'(ram_oe), 32'd1);
    chk("sw_c1_in_ready", 32'(in_ready), 32'd0);
    tick();
    out_ready = 1'b1;
    #1;
    chk("sw_c2_valid", 32'(out_valid), 32'd1);
    chk("sw_c2_data", 32'(out_data), 32'h11);
    chk("sw_c2_level", 32'(level), 32'd1);
    tick();
    out_ready = 1'b0;
    #1;
    chk("sw_c3_valid", 32'(out_valid), 32'd0);
    chk("sw_c3_level", 32'(level), 32'd0);
    chk("sw_c3_oe", 32'(ram_oe), 32'd0);
    tick();

    // Fill with out_ready low: offered A0..A5.
    begin
      logic [6:0] exp_rdy;
      int idx;
      exp_rdy = 7'b0111101; // bit c = expected in_ready in cycle c
      idx = 0;
      for (int c = 0; c < 7; c++) begin
        in_valid = 1'b1;
        in_data  = 8'hA0 + 8'(idx);
        #1;
        chk($sformatf("fill_c%0d_in_ready", c), 32'(in_ready), 32'(exp_rdy[c]));
        if (c == 6) begin
          chk("fill_full_level", 32'(level), 32'd5);
          chk("fill_full_we", 32'(ram_we), 32'd0);
          chk("fill_head", 32'(out_data), 32'hA0);
        end else begin
          tick();
        end
        if (exp_rdy[c]) idx++;
      end
    end

    // Pop once while full: refill in the same cycle, in_ready rises after.
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("full_pop_oe", 32'(ram_oe), 32'd1);
    chk("full_pop_in_ready", 32'(in_ready), 32'd0);
    tick();
    out_ready = 1'b0;
    #1;
    chk("after_full_in_ready", 32'(in_ready), 32'd1);
    chk("after_full_level", 32'(level), 32'd4);
    chk("after_full_data", 32'(out_data), 32'hA1);

    // Drain remaining words on consecutive cycles.
    for (int k = 1; k < 5; k++) begin
      out_ready = 1'b1;
      #1;
      chk($sformatf("drain_%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("drain_%0d_data", k), 32'(out_data), 32'(8'hA0 + 8'(k)));
      tick();
    end
    out_ready = 1'b0;
    #1;
    chk("drain_end_valid", 32'(out_valid), 32'd0);
    chk("drain_end_level", 32'(level), 32'd0);
    // Six pushes and six reads since reset: both pointers sit at 2.
    chk("wrap_start_wr_ptr", 32'(ram_address), 32'd2);
    tick();

    // Wrap: ten pushes interleaved with pops, order preserved.
    for (int i = 0; i < 10; i++) begin
      do_push(8'(i));
      if (i >= 2) do_pop(8'(i - 2));
    end
    do_pop(8'h08);
    do_pop(8'h09);
    #1;
    chk("wrap_end_level", 32'(level), 32'd0);
    chk("wrap_end_wr_ptr", 32'(ram_address), 32'd0);
    tick();

    // Async reset mid-stream with three words stored.
    do_push(8'hB0);
    do_push(8'hB1);
    do_push(8'hB2);
    #1;
    chk("pre_reset_level", 32'(level), 32'd3);
    in_valid = 1'b1; in_data = 8'h77;
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_level", 32'(level), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd0);
    chk("async_rst_we", 32'(ram_we), 32'd0);
    tick();
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    do_push(8'h5A);
    do_pop(8'h5A);
    #1;
    chk("post_reset_level", 32'(level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
